spi_txn_controller: RTL and testbench
=====================================

// Module: spi_txn_controller
// PURPOSE
//   Sequences the spi_master for multi-byte transfers to one of NUM_SLAVES SPI slaves.
//   Accepts a command (slave index, byte count), then streams TX bytes into the master
//   one at a time and returns the received bytes.
//   Drives the active-low chip selects with programmable setup, hold and gap timing.
//   Sits between the system/command logic and spi_master; one master, many slaves.
// PARAMETERS
//   NUM_SLAVES     4  number of chip-select lines (1..2**CS_W)
//   CS_W           2  width of slave-index field
//   LEN_W          8  width of length field; bytes per transfer = r_cmd_len+1 (1..2**LEN_W)
//   CS_SETUP_CLKS  4  r_clk cycles CS held low before first byte is offered (>=1)
//   CS_HOLD_CLKS   4  r_clk cycles CS held low after last r_m_done (>=1)
//   CS_GAP_CLKS    4  r_clk cycles all CS high before next command accepted (>=1)
// PORTS
//   r_clk          in   1           system clock, all logic on rising edge
//   r_reset        in   1           asynchronous, active-high reset
//   r_cmd_valid    in   1           command request
//   w_cmd_ready    out  1           high only in IDLE; accept = r_cmd_valid & w_cmd_ready
//   r_cmd_cs       in   CS_W        target slave index
//   r_cmd_len      in   LEN_W       byte count minus one
//   r_tx_byte      in   8           next byte to transmit
//   r_tx_valid     in   1           r_tx_byte valid
//   w_tx_ready     out  1           high only in WAIT_TX; byte taken on valid & ready
//   w_rx_byte      out  8           received byte, stable until next w_rx_valid
//   w_rx_valid     out  1           1-cycle pulse per received byte (no backpressure)
//   w_txn_done     out  1           1-cycle pulse when transfer fully complete (entering IDLE)
//   w_cmd_err      out  1           1-cycle pulse: r_cmd_cs >= NUM_SLAVES, command dropped
//   w_busy         out  1           high in every state except IDLE
//   w_cs_n         out  NUM_SLAVES  active-low chip selects, at most one low at a time
//   w_m_data       out  8           to spi_master r_data; stable from SEND until r_m_done
//   w_m_data_ready out  1           to spi_master r_data_ready; 1-cycle start pulse
//   r_m_ready      in   1           from spi_master w_data_ready
//   r_m_done       in   1           from spi_master w_master_done; 1-cycle pulse
//   r_m_data       in   8           from spi_master w_data; valid with r_m_done
// BEHAVIOUR
//   Reset (async, immediate):
//     state=IDLE, w_cs_n all 1, all pulses 0, w_m_data=0, w_rx_byte=0.
//     Internal counters cleared; w_cmd_ready=1 after reset release.
//     Reset mid-transfer deasserts CS immediately; the in-flight byte is abandoned.
//   States: IDLE, CS_SETUP, WAIT_TX, SEND, WAIT_DONE, CS_HOLD, CS_GAP.
//   IDLE
//     On accept with valid index: latch cs index, remaining = r_cmd_len -> CS_SETUP;
//     the selected w_cs_n bit goes low at the next edge.
//     On accept with invalid index: pulse w_cmd_err next cycle, stay IDLE, CS untouched.
//   CS_SETUP: count CS_SETUP_CLKS cycles -> WAIT_TX.
//   WAIT_TX: w_tx_ready=1; on handshake w_m_data<=r_tx_byte -> SEND.
//     Underrun (no r_tx_valid): wait indefinitely with CS held low.
//   SEND: when r_m_ready=1, pulse w_m_data_ready for exactly 1 cycle -> WAIT_DONE.
//     If r_m_ready=0, wait.
//   WAIT_DONE: r_m_done is honoured only in this state (ignored elsewhere). On r_m_done:
//     w_rx_byte<=r_m_data and w_rx_valid pulses on the next cycle.
//     If remaining==0 -> CS_HOLD; else remaining-=1 -> WAIT_TX.
//   CS_HOLD: CS_HOLD_CLKS cycles, then all w_cs_n high -> CS_GAP.
//   CS_GAP: CS_GAP_CLKS cycles -> IDLE, with w_txn_done pulsing that cycle.
//   r_cmd_* are ignored while w_busy=1; a command held valid is accepted on return to IDLE.
//   Remaining counter is LEN_W bits with no wrap: len=2**LEN_W-1 gives 2**LEN_W bytes.
// TESTING
//   1. Reset, then cmd cs=1 len=0, tx 0xC1, master model echoes 0x3C ->
//      w_cs_n=4'b1101 for SETUP+1 byte+HOLD cycles; one rx 0x3C; one w_txn_done.
//   2. cmd cs=2 len=3, tx A5,5A,FF,00 ->
//      exactly 4 w_m_data_ready pulses in order; CS stays low between bytes; 4 w_rx_valid.
//   3. cmd cs=0 len=1, r_tx_valid withheld 50 cycles before byte 2 ->
//      w_cs_n[0] remains 0 throughout; no extra w_m_data_ready.
//   4. cmd cs=3 with NUM_SLAVES=3 -> w_cmd_err pulse; w_cs_n stays all 1; no SPI activity.
//   5. Assert r_reset during WAIT_DONE of byte 2 of 4 ->
//      w_cs_n all 1 same cycle; no w_rx_valid/w_txn_done; a fresh cmd afterwards runs normally.
//   6. Back-to-back cmds with r_cmd_valid held -> second CS low only after CS_GAP_CLKS high cycles.

Source files
------------

// File: rtl/spi_txn_controller.sv
// spi_txn_controller: sequences spi_master for multi-byte
// transfers to one of NUM_SLAVES slaves with CS timing.
//
// Ports:
//   r_clk, r_reset      clock, async active-high reset
//   r_cmd_valid/cs/len  command in (len = bytes - 1)
//   w_cmd_ready         high in IDLE
//   r_tx_byte/valid     tx byte stream in
//   w_tx_ready          high in WAIT_TX
//   w_rx_byte/valid     rx byte out, 1-cycle valid pulse
//   w_txn_done          1-cycle pulse on return to IDLE
//   w_cmd_err           1-cycle pulse for bad slave index
//   w_busy              high outside IDLE
//   w_cs_n              active-low chip selects
//   w_m_data/_ready     byte + start pulse to spi_master
//   r_m_ready/done/data handshake back from spi_master
module spi_txn_controller #(
  parameter int NUM_SLAVES    = 4,
  parameter int CS_W          = 2,
  parameter int LEN_W         = 8,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int CS_GAP_CLKS   = 4
) (
  input  logic                  r_clk,
  input  logic                  r_reset,
  input  logic                  r_cmd_valid,
  output logic                  w_cmd_ready,
  input  logic [CS_W-1:0]       r_cmd_cs,
  input  logic [LEN_W-1:0]      r_cmd_len,
  input  logic [7:0]            r_tx_byte,
  input  logic                  r_tx_valid,
  output logic                  w_tx_ready,
  output logic [7:0]            w_rx_byte,
  output logic                  w_rx_valid,
  output logic                  w_txn_done,
  output logic                  w_cmd_err,
  output logic                  w_busy,
  output logic [NUM_SLAVES-1:0] w_cs_n,
  output logic [7:0]            w_m_data,
  output logic                  w_m_data_ready,
  input  logic                  r_m_ready,
  input  logic                  r_m_done,
  input  logic [7:0]            r_m_data
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    WAIT_TX,
    SEND,
    WAIT_DONE,
    CS_HOLD,
    CS_GAP
  } state_t;

  localparam int CNT_W = 16;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] remaining;
  logic             accept;
  logic             cs_bad;

  assign accept = r_cmd_valid && (state == IDLE);

  // Extra bit so NUM_SLAVES == 2**CS_W does not truncate.
  assign cs_bad = {1'b0, r_cmd_cs} >=
                  (CS_W+1)'(NUM_SLAVES);

  assign w_cmd_ready    = (state == IDLE);
  assign w_busy         = (state != IDLE);
  assign w_tx_ready     = (state == WAIT_TX);
  assign w_m_data_ready = (state == SEND) && r_m_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept && !cs_bad)
          state_nx = CS_SETUP;
      CS_SETUP:
        if (cnt == CNT_W'(CS_SETUP_CLKS - 1))
          state_nx = WAIT_TX;
      WAIT_TX:
        if (r_tx_valid)
          state_nx = SEND;
      SEND:
        if (r_m_ready)
          state_nx = WAIT_DONE;
      WAIT_DONE:
        if (r_m_done)
          state_nx = (remaining == '0) ?
                     CS_HOLD : WAIT_TX;
      CS_HOLD:
        if (cnt == CNT_W'(CS_HOLD_CLKS - 1))
          state_nx = CS_GAP;
      CS_GAP:
        if (cnt == CNT_W'(CS_GAP_CLKS - 1))
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or posedge r_reset) begin
    if (r_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      remaining  <= '0;
      w_cs_n     <= '1;
      w_m_data   <= '0;
      w_rx_byte  <= '0;
      w_rx_valid <= 1'b0;
      w_txn_done <= 1'b0;
      w_cmd_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      // Timer restarts on every state change.
      cnt        <= (state_nx == state) ?
                    cnt + 1'b1 : '0;
      w_rx_valid <= 1'b0;
      w_txn_done <= 1'b0;
      w_cmd_err  <= accept && cs_bad;
      if (accept && !cs_bad) begin
        remaining <= r_cmd_len;
        w_cs_n    <= ~(NUM_SLAVES'(1) << r_cmd_cs);
      end
      if (state == WAIT_TX && r_tx_valid)
        w_m_data <= r_tx_byte;
      if (state == WAIT_DONE && r_m_done) begin
        w_rx_byte  <= r_m_data;
        w_rx_valid <= 1'b1;
        if (remaining != '0)
          remaining <= remaining - 1'b1;
      end
      if (state == CS_HOLD && state_nx == CS_GAP)
        w_cs_n <= '1;
      if (state == CS_GAP && state_nx == IDLE)
        w_txn_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_txn_controller.sv
// tb_spi_txn_controller: directed bench with a
// spi_master responder and byte scoreboards.
module tb_spi_txn_controller;

  localparam int NS = 3;
  localparam int CW = 2;
  localparam int LW = 8;
  localparam int SU = 4;
  localparam int HD = 4;
  localparam int GP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_cs = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [7:0]    tx_byte = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          txn_done;
  logic          cmd_err;
  logic          busy;
  logic [NS-1:0] cs_n;
  logic [7:0]    m_data;
  logic          m_data_ready;
  logic          m_ready = 1'b1;
  logic          m_done = 1'b0;
  logic [7:0]    m_rdata = '0;

  always #5 clk = ~clk;

  spi_txn_controller #(
    .NUM_SLAVES(NS), .CS_W(CW), .LEN_W(LW),
    .CS_SETUP_CLKS(SU), .CS_HOLD_CLKS(HD),
    .CS_GAP_CLKS(GP)
  ) dut (
    .r_clk(clk),
    .r_reset(rst),
    .r_cmd_valid(cmd_valid),
    .w_cmd_ready(cmd_ready),
    .r_cmd_cs(cmd_cs),
    .r_cmd_len(cmd_len),
    .r_tx_byte(tx_byte),
    .r_tx_valid(tx_valid),
    .w_tx_ready(tx_ready),
    .w_rx_byte(rx_byte),
    .w_rx_valid(rx_valid),
    .w_txn_done(txn_done),
    .w_cmd_err(cmd_err),
    .w_busy(busy),
    .w_cs_n(cs_n),
    .w_m_data(m_data),
    .w_m_data_ready(m_data_ready),
    .r_m_ready(m_ready),
    .r_m_done(m_done),
    .r_m_data(m_rdata)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_md[$];
  logic [7:0] exp_rx[$];
  int mdr_cnt, rxv_cnt, done_cnt, err_cnt;
  int low_cnt, low_starts, bad_pat;
  int high_run, last_high;
  logic prev_low = 1'b0;
  logic [NS-1:0] cs_pat = '1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  // spi_master stand-in: 3 cycles busy, replies tx^FD.
  int lat = 0;
  logic [7:0] cap;
  always @(negedge clk) begin
    if (rst) begin
      lat = 0;
      m_ready = 1'b1;
      m_done = 1'b0;
    end else if (lat > 0) begin
      m_ready = 1'b0;
      lat--;
      if (lat == 0) begin
        m_done = 1'b1;
        m_rdata = cap ^ 8'hFD;
      end
    end else begin
      m_done = 1'b0;
      m_ready = 1'b1;
      if (m_data_ready) begin
        cap = m_data;
        lat = 3;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (m_data_ready) begin
      mdr_cnt++;
      e = 8'hxx;
      if (exp_md.size() > 0) e = exp_md.pop_front();
      chk("m_data", m_data, e);
    end
    if (rx_valid) begin
      rxv_cnt++;
      e = 8'hxx;
      if (exp_rx.size() > 0) e = exp_rx.pop_front();
      chk("rx_byte", rx_byte, e);
    end
    if (txn_done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (cs_n != '1) begin
      low_cnt++;
      if (cs_n !== cs_pat) bad_pat++;
      if (!prev_low) begin
        low_starts++;
        last_high = high_run;
      end
      high_run = 0;
      prev_low = 1'b1;
    end else begin
      high_run++;
      prev_low = 1'b0;
    end
  end

  task automatic clr();
    mdr_cnt = 0; rxv_cnt = 0; done_cnt = 0;
    err_cnt = 0; low_cnt = 0; low_starts = 0;
    bad_pat = 0;
  endtask

  task automatic send_cmd(input logic [CW-1:0] cs,
                          input logic [LW-1:0] len);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_cs = cs;
    cmd_len = len;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_timeout", 32'(n < 200), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b);
    int n;
    @(negedge clk);
    tx_byte = b;
    tx_valid = 1'b1;
    exp_md.push_back(b);
    exp_rx.push_back(b ^ 8'hFD);
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("tx_timeout", 32'(n < 500), 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_txn();
    int n;
    n = 0;
    while (!txn_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("txn_timeout", 32'(n < 2000), 1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 3'b111);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rx_byte", rx_byte, 0);
    rst = 1'b0;
    settle();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pulses",
        {rx_valid, txn_done, cmd_err, m_data_ready}, 0);
    clr();

    // 1: single byte to slave 1
    cs_pat = 3'b101;
    send_cmd(2'd1, 8'd0);
    feed(8'hC1);
    wait_txn();
    settle();
    chk("t1_low_cycles", low_cnt, SU + 5 + HD);
    chk("t1_cs_pattern", bad_pat, 0);
    chk("t1_rx_count", rxv_cnt, 1);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_mdr_count", mdr_cnt, 1);
    chk("t1_last_rx", rx_byte, 8'h3C);
    clr();

    // 2: four bytes to slave 2
    cs_pat = 3'b011;
    send_cmd(2'd2, 8'd3);
    feed(8'hA5);
    feed(8'h5A);
    feed(8'hFF);
    feed(8'h00);
    wait_txn();
    settle();
    chk("t2_mdr_count", mdr_cnt, 4);
    chk("t2_rx_count", rxv_cnt, 4);
    chk("t2_cs_starts", low_starts, 1);
    chk("t2_low_cycles", low_cnt, SU + 4 * 5 + HD);
    chk("t2_cs_pattern", bad_pat, 0);
    chk("t2_done_count", done_cnt, 1);
    clr();

    // 3: tx underrun before byte 2
    cs_pat = 3'b110;
    send_cmd(2'd0, 8'd1);
    feed(8'h12);
    repeat (50) @(negedge clk);
    chk("t3_cs_held", cs_n, 3'b110);
    chk("t3_tx_ready", tx_ready, 1);
    chk("t3_mdr_wait", mdr_cnt, 1);
    feed(8'h34);
    wait_txn();
    settle();
    chk("t3_mdr_count", mdr_cnt, 2);
    chk("t3_rx_count", rxv_cnt, 2);
    chk("t3_cs_starts", low_starts, 1);
    chk("t3_cs_pattern", bad_pat, 0);
    clr();

    // 4: invalid slave index
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_cs = 2'd3;
    cmd_len = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_err_pulse", cmd_err, 1);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    chk("t4_err_clear", cmd_err, 0);
    repeat (20) @(negedge clk);
    #1;
    chk("t4_err_count", err_cnt, 1);
    chk("t4_no_cs", low_cnt, 0);
    chk("t4_no_spi", mdr_cnt, 0);
    clr();

    // 5: reset inside WAIT_DONE of byte 2
    cs_pat = 3'b101;
    send_cmd(2'd1, 8'd3);
    feed(8'h11);
    feed(8'h22);
    @(negedge clk);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_cs", cs_n, 3'b101);
    chk("t5_pre_txrdy", tx_ready, 0);
    rst = 1'b1;
    #1;
    chk("t5_cs_async", cs_n, 3'b111);
    chk("t5_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_rx_count", rxv_cnt, 1);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_rx_byte", rx_byte, 0);
    exp_rx.delete();
    exp_md.delete();
    clr();
    cs_pat = 3'b011;
    send_cmd(2'd2, 8'd0);
    feed(8'h77);
    wait_txn();
    settle();
    chk("t5_new_low", low_cnt, SU + 5 + HD);
    chk("t5_new_rx", rxv_cnt, 1);
    chk("t5_new_done", done_cnt, 1);
    chk("t5_new_byte", rx_byte, 8'h77 ^ 8'hFD);
    clr();

    // 6: back-to-back with command held valid
    cs_pat = 3'b110;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_cs = 2'd0;
    cmd_len = 8'd0;
    feed(8'h81);
    wait_txn();
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_reaccept", busy, 1);
    feed(8'h82);
    wait_txn();
    settle();
    chk("t6_gap_high", last_high, GP + 1);
    chk("t6_cs_starts", low_starts, 2);
    chk("t6_done_count", done_cnt, 2);
    chk("t6_rx_count", rxv_cnt, 2);
    chk("t6_mdr_count", mdr_cnt, 2);

    chk("md_queue_left", exp_md.size(), 0);
    chk("rx_queue_left", exp_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
